// File: rtl/div_ctrl_pkg.sv
// Shared encodings and constants for the multi-cycle divide controller.
package div_ctrl_pkg;

    localparam logic [1:0] DIV_NONE     = 2'b00;
    localparam logic [1:0] DIV_SIGNED   = 2'b01;
    localparam logic [1:0] DIV_UNSIGNED = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } divState_t;

    localparam logic [5:0]  DIV_TIMEOUT = 6'd63;
    localparam logic        RESETABLE   = 1'b0;
    localparam logic [31:0] ZEROWORD    = 32'h0;

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == DIV_SIGNED) || (op == DIV_UNSIGNED);
    endfunction

endpackage

// File: rtl/div_busy_cnt.sv
// Saturating 6-bit counter of cycles spent waiting on the external divider.
module div_busy_cnt
    import div_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    output logic [5:0] count
);

    always_ff @(posedge clock) begin
        if (reset == RESETABLE)
            count <= 6'd0;
        else if (clear)
            count <= 6'd0;
        else if (en && (count != DIV_TIMEOUT))
            count <= count + 6'd1;
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequences a divide in EX against an external divider: start, stall, capture,
// cancel on annul or timeout, and a one-cycle HI/LO write-valid.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  isDivE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_cancel,
    output logic        StallDiv,
    output logic        DivValid,
    output logic [31:0] HiDiv,
    output logic [31:0] LoDiv
);

    divState_t  state, nextState;
    logic [5:0] busyCnt;
    logic       divReq, startHit, zeroHit, readyHit, timeout;

    assign divReq   = isDivOp(isDivE) && !annul;
    assign startHit = (state == ST_IDLE) && divReq && (SrcBE != ZEROWORD);
    assign zeroHit  = (state == ST_IDLE) && divReq && (SrcBE == ZEROWORD);
    assign readyHit = (state == ST_BUSY) && !annul && div_ready;
    // Timeout only fires when the divider has not answered in the same cycle.
    assign timeout  = (state == ST_BUSY) && !annul && !div_ready && (busyCnt == DIV_TIMEOUT);

    div_busy_cnt uBusyCnt (
        .clock (clock),
        .reset (reset),
        .clear (startHit),
        .en    (state == ST_BUSY),
        .count (busyCnt)
    );

    always_ff @(posedge clock) begin
        if (reset == RESETABLE)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (startHit)     nextState = ST_BUSY;
                else if (zeroHit) nextState = ST_DONE;
            end
            ST_BUSY: begin
                if (annul)                    nextState = ST_IDLE;
                else if (div_ready || timeout) nextState = ST_DONE;
            end
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        div_start  = 1'b0;
        div_cancel = 1'b0;
        StallDiv   = 1'b0;
        DivValid   = 1'b0;
        if (reset != RESETABLE) begin
            case (state)
                ST_IDLE: begin
                    div_start = startHit;
                    StallDiv  = startHit || zeroHit;
                end
                ST_BUSY: begin
                    StallDiv   = 1'b1;
                    div_cancel = annul || timeout;
                end
                ST_DONE: DivValid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset == RESETABLE) begin
            div_opa    <= ZEROWORD;
            div_opb    <= ZEROWORD;
            div_signed <= 1'b0;
            HiDiv      <= ZEROWORD;
            LoDiv      <= ZEROWORD;
        end else begin
            if (startHit) begin
                div_opa    <= SrcAE;
                div_opb    <= SrcBE;
                div_signed <= (isDivE == DIV_SIGNED);
            end
            if (zeroHit) begin
                HiDiv <= SrcAE;
                LoDiv <= 32'hFFFF_FFFF;
            end else if (readyHit) begin
                HiDiv <= div_result[63:32];
                LoDiv <= div_result[31:0];
            end else if (timeout) begin
                HiDiv <= ZEROWORD;
                LoDiv <= ZEROWORD;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: signed, divide-by-zero, annul, timeout,
// back-to-back and reset-during-busy sequences with hand-computed results.
module tb_div_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  isDivE;
    logic [31:0] SrcAE, SrcBE;
    logic        annul, div_ready;
    logic [63:0] div_result;
    logic        div_start, div_signed, div_cancel, StallDiv, DivValid;
    logic [31:0] div_opa, div_opb, HiDiv, LoDiv;

    int chkCnt  = 0;
    int passCnt = 0;
    int startCnt = 0, cancelCnt = 0, validCnt = 0, stallCnt = 0;
    int s0, c0, v0, t0;
    logic early;

    always #5 clock = ~clock;

    div_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .isDivE     (isDivE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .annul      (annul),
        .div_ready  (div_ready),
        .div_result (div_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .div_cancel (div_cancel),
        .StallDiv   (StallDiv),
        .DivValid   (DivValid),
        .HiDiv      (HiDiv),
        .LoDiv      (LoDiv)
    );

    // Pulse counters sampled mid-cycle, well away from the active edge.
    always @(negedge clock) begin
        if (div_start)  startCnt  <= startCnt + 1;
        if (div_cancel) cancelCnt <= cancelCnt + 1;
        if (DivValid)   validCnt  <= validCnt + 1;
        if (StallDiv)   stallCnt  <= stallCnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic snap();
        s0 = startCnt; c0 = cancelCnt; v0 = validCnt; t0 = stallCnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; isDivE = 2'b00; SrcAE = '0; SrcBE = '0;
        annul = 1'b0; div_ready = 1'b0; div_result = '0;

        // Reset state, and outputs gated while reset is low even with a divide presented.
        tick(); tick();
        isDivE = 2'b01; SrcAE = 32'd9; SrcBE = 32'd3;
        #1;
        chk("rst start", div_start, 0);
        chk("rst stall", StallDiv, 0);
        chk("rst valid", DivValid, 0);
        chk("rst hi", HiDiv, 0);
        chk("rst lo", LoDiv, 0);
        chk("rst opa", div_opa, 0);

        // Signed -7 / 2, divider answers 32 cycles after start.
        tick();
        reset = 1'b1; isDivE = 2'b01; SrcAE = 32'hFFFF_FFF9; SrcBE = 32'd2;
        snap();
        #1;
        chk("t1 start", div_start, 1);
        chk("t1 stall0", StallDiv, 1);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 32) begin div_ready = 1'b1; div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD}; end
            #1;
            if (i == 1) begin
                chk("t1 opa", div_opa, 32'hFFFF_FFF9);
                chk("t1 opb", div_opb, 32'd2);
                chk("t1 signed", div_signed, 1);
                chk("t1 start once", div_start, 0);
            end
            if (i == 32) chk("t1 stall32", StallDiv, 1);
        end
        tick(); div_ready = 1'b0;
        #1;
        chk("t1 valid", DivValid, 1);
        chk("t1 stall done", StallDiv, 0);
        chk("t1 hi", HiDiv, 32'hFFFF_FFFF);
        chk("t1 lo", LoDiv, 32'hFFFF_FFFD);
        tick(); isDivE = 2'b00;
        #1;
        chk("t1 valid drop", DivValid, 0);
        chk("t1 n start", startCnt - s0, 1);
        chk("t1 n stall", stallCnt - t0, 33);
        chk("t1 n valid", validCnt - v0, 1);

        // Divide by zero: result next cycle, no divider start.
        tick();
        isDivE = 2'b10; SrcAE = 32'h1234; SrcBE = 32'h0;
        snap();
        #1;
        chk("t2 start", div_start, 0);
        chk("t2 stall", StallDiv, 1);
        tick(); isDivE = 2'b00;
        #1;
        chk("t2 valid", DivValid, 1);
        chk("t2 lo", LoDiv, 32'hFFFF_FFFF);
        chk("t2 hi", HiDiv, 32'h1234);
        tick(); #1;
        chk("t2 n start", startCnt - s0, 0);
        chk("t2 n valid", validCnt - v0, 1);

        // Annul at busy cycle 10 with a coincident div_ready.
        isDivE = 2'b10; SrcAE = 32'd100; SrcBE = 32'd7;
        snap();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 10) begin annul = 1'b1; div_ready = 1'b1; div_result = {32'd5, 32'd77}; end
        end
        #1;
        chk("t3 cancel", div_cancel, 1);
        tick(); annul = 1'b0; div_ready = 1'b0; isDivE = 2'b00;
        #1;
        chk("t3 stall drop", StallDiv, 0);
        tick(); tick(); #1;
        chk("t3 n cancel", cancelCnt - c0, 1);
        chk("t3 n valid", validCnt - v0, 0);
        chk("t3 hi kept", HiDiv, 32'h1234);
        chk("t3 lo kept", LoDiv, 32'hFFFF_FFFF);

        // Divider never answers: cancel on the 64th busy cycle.
        isDivE = 2'b01; SrcAE = 32'd5; SrcBE = 32'd3;
        snap();
        early = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick(); #1;
            if (i < 64) early = early | div_cancel;
            else chk("t4 cancel", div_cancel, 1);
        end
        chk("t4 early cancel", early, 0);
        tick(); isDivE = 2'b00;
        #1;
        chk("t4 valid", DivValid, 1);
        chk("t4 hi", HiDiv, 0);
        chk("t4 lo", LoDiv, 0);
        tick(); #1;
        chk("t4 idle", StallDiv | DivValid, 0);
        chk("t4 n cancel", cancelCnt - c0, 1);

        // Back-to-back unsigned: 100/7 (N=3) then 50/8 (N=2) right after DONE.
        isDivE = 2'b10; SrcAE = 32'd100; SrcBE = 32'd7;
        snap();
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 3) begin div_ready = 1'b1; div_result = {32'd2, 32'd14}; end
        end
        tick(); div_ready = 1'b0;
        #1;
        chk("t5 valid a", DivValid, 1);
        chk("t5 lo a", LoDiv, 32'd14);
        tick(); SrcAE = 32'd50; SrcBE = 32'd8;
        #1;
        chk("t5 start b", div_start, 1);
        for (int i = 1; i <= 2; i++) begin
            tick();
            if (i == 2) begin div_ready = 1'b1; div_result = {32'd2, 32'd6}; end
        end
        #1;
        chk("t5 opa b", div_opa, 32'd50);
        chk("t5 signed b", div_signed, 0);
        tick(); div_ready = 1'b0; isDivE = 2'b00;
        #1;
        chk("t5 hi b", HiDiv, 32'd2);
        chk("t5 lo b", LoDiv, 32'd6);
        tick(); tick(); #1;
        chk("t5 n start", startCnt - s0, 2);
        chk("t5 n valid", validCnt - v0, 2);

        // Reset while busy: everything clears, no cancel pulse.
        isDivE = 2'b01; SrcAE = 32'd9; SrcBE = 32'd2;
        tick(); tick(); tick();
        snap();
        reset = 1'b0;
        #1;
        chk("t6 gated stall", StallDiv, 0);
        chk("t6 gated cancel", div_cancel, 0);
        tick(); reset = 1'b1; isDivE = 2'b00;
        #1;
        chk("t6 stall", StallDiv, 0);
        chk("t6 hi", HiDiv, 0);
        chk("t6 opa", div_opa, 0);
        tick(); #1;
        chk("t6 n cancel", cancelCnt - c0, 0);
        chk("t6 idle", DivValid | StallDiv, 0);

        $display("%0d/%0d checks passed", passCnt, chkCnt);
        $finish;
    end

endmodule
